mar_access_sequencer: RTL and testbench

//  Sequences and shares the 6-bit memory address register (MAR) between two requesters:

---
 rtl/mar_access_sequencer.sv | 118 +++++++++++
 tb/tb_mar_access_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mar_access_sequencer.sv
// Shares the MAR between a fetch requester and a data requester: arbitrates,
// loads the MAR, runs the memory access with wait states and timeout, then acks.
module mar_access_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mar_in,
  output logic              mar_ls,
  output logic              mem_en,
  output logic              mem_we,
  output logic              f_ack,
  output logic              d_ack,
  output logic              d_err,
  output logic              f_err,
  output logic              busy
);

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned TCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  logic                win_d;   // current winner: 1 = data, 0 = fetch
  logic                last_d;  // last served requester: 1 = data
  logic                we_q;
  logic [WCNT_W-1:0]   wcnt;
  logic [TCNT_W-1:0]   tcnt;

  logic grant_d_c;
  logic ok_c;
  logic tmo_c;

  // Data wins when alone, or on a tie when fetch was served last.
  assign grant_d_c = d_req & (~f_req | ~last_d);
  assign ok_c      = (wcnt == '0) & mem_ready;
  assign tmo_c     = (tcnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      win_d  <= 1'b0;
      last_d <= 1'b1;
      we_q   <= 1'b0;
      wcnt   <= '0;
      tcnt   <= '0;
      mar_in <= '0;
      mar_ls <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      f_ack  <= 1'b0;
      d_ack  <= 1'b0;
      f_err  <= 1'b0;
      d_err  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            win_d  <= grant_d_c;
            we_q   <= grant_d_c & d_we;
            mar_in <= grant_d_c ? d_addr : f_addr;
            mar_ls <= 1'b1;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          mar_ls <= 1'b0;
          mem_en <= 1'b1;
          mem_we <= we_q;
          wcnt   <= WCNT_W'(WAIT_CYCLES);
          tcnt   <= '0;
          state  <= ACCESS;
        end
        ACCESS: begin
          if (wcnt != '0) wcnt <= wcnt - WCNT_W'(1);
          tcnt <= tcnt + TCNT_W'(1);
          // A completed access wins over a timeout on the same edge.
          if (ok_c || tmo_c) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            f_ack  <= ~win_d;
            d_ack  <= win_d;
            f_err  <= ~win_d & ~ok_c;
            d_err  <= win_d & ~ok_c;
            state  <= RESP;
          end
        end
        RESP: begin
          f_ack  <= 1'b0;
          d_ack  <= 1'b0;
          f_err  <= 1'b0;
          d_err  <= 1'b0;
          busy   <= 1'b0;
          last_d <= win_d;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mar_access_sequencer.sv
// Self-checking bench for mar_access_sequencer: directed tables and sequences plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_mar_access_sequencer;

  localparam int unsigned AW   = 6;
  localparam int unsigned WAIT = 1;
  localparam int unsigned TMO  = 8;

  logic          clk;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic          mem_ready;

  logic [AW-1:0] mar_in;
  logic          mar_ls, mem_en, mem_we, f_ack, d_ack, d_err, f_err, busy;
  logic [AW-1:0] mar_in3;
  logic          mar_ls3, mem_en3, mem_we3, f_ack3, d_ack3, d_err3, f_err3, busy3;

  mar_access_sequencer #(.ADDR_W(AW), .WAIT_CYCLES(WAIT), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .mem_ready(mem_ready), .mar_in(mar_in), .mar_ls(mar_ls),
    .mem_en(mem_en), .mem_we(mem_we), .f_ack(f_ack), .d_ack(d_ack), .d_err(d_err),
    .f_err(f_err), .busy(busy)
  );

  mar_access_sequencer #(.ADDR_W(AW), .WAIT_CYCLES(3), .TIMEOUT(TMO)) u_dut3 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .mem_ready(mem_ready), .mar_in(mar_in3), .mar_ls(mar_ls3),
    .mem_en(mem_en3), .mem_we(mem_we3), .f_ack(f_ack3), .d_ack(d_ack3), .d_err(d_err3),
    .f_err(f_err3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: a transaction seen as phases (idle, load, access, resp)
  // with a count of access cycles already spent.
  int            m_ph;
  int            m_n;
  logic          m_who;
  logic          m_last;
  logic          m_we;
  logic          m_err;
  logic [AW-1:0] m_mar;

  task automatic model_reset();
    m_ph = 0; m_n = 0; m_who = 1'b0; m_last = 1'b1; m_we = 1'b0; m_err = 1'b0; m_mar = '0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: if (f_req || d_req) begin
        if (f_req && d_req) m_who = ~m_last;
        else m_who = d_req;
        m_mar = m_who ? d_addr : f_addr;
        m_we  = m_who && d_we;
        m_ph  = 1;
      end
      1: begin m_ph = 2; m_n = 0; end
      2: begin
        if (m_n >= int'(WAIT) && mem_ready) begin m_err = 1'b0; m_ph = 3; end
        else if (m_n == int'(TMO) - 1) begin m_err = 1'b1; m_ph = 3; end
        else m_n++;
      end
      default: begin m_last = m_who; m_ph = 0; end
    endcase
  endtask

  function automatic logic [13:0] mk(input logic [AW-1:0] a, input logic ls, input logic en,
                                     input logic we, input logic fa, input logic da,
                                     input logic fe, input logic de, input logic bz);
    return {a, ls, en, we, fa, da, fe, de, bz};
  endfunction

  function automatic logic [13:0] model_out();
    logic r;
    r = (m_ph == 3);
    return mk(m_mar, m_ph == 1, m_ph == 2, (m_ph == 2) && m_we, r && !m_who, r && m_who,
              r && !m_who && m_err, r && m_who && m_err, m_ph != 0);
  endfunction

  function automatic logic [13:0] dut_out();
    return {mar_in, mar_ls, mem_en, mem_we, f_ack, d_ack, f_err, d_err, busy};
  endfunction

  // One clock: inputs are already applied; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    check("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic do_reset();
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic          ready;
    logic [13:0]   exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int acks, lss, en_cnt, we_seen, bias;
    bit got;
    int order [$];

    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acks, lss, en_cnt, bias;
    bit got, we_seen;
    int order [$];

    rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    mem_ready = 1'b0;
    model_reset();
    step();
    check("reset_state", 32'(dut_out()), 32'(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    step();

    // Single uncontended fetch, WAIT=1, memory always ready.
    vecs[0] = '{1'b1, 6'h2A, 1'b0, 1'b0, 6'h00, 1'b1, mk(6'h2A, 1, 0, 0, 0, 0, 0, 0, 1)};
    vecs[1] = '{1'b1, 6'h2A, 1'b0, 1'b0, 6'h00, 1'b1, mk(6'h2A, 0, 1, 0, 0, 0, 0, 0, 1)};
    vecs[2] = '{1'b1, 6'h2A, 1'b0, 1'b0, 6'h00, 1'b1, mk(6'h2A, 0, 1, 0, 0, 0, 0, 0, 1)};
    vecs[3] = '{1'b1, 6'h2A, 1'b0, 1'b0, 6'h00, 1'b1, mk(6'h2A, 0, 0, 0, 1, 0, 0, 0, 1)};
    vecs[4] = '{1'b0, 6'h2A, 1'b0, 1'b0, 6'h00, 1'b1, mk(6'h2A, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5] = '{1'b0, 6'h2A, 1'b0, 1'b0, 6'h00, 1'b1, mk(6'h2A, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      f_req = vecs[i].f_req; f_addr = vecs[i].f_addr; d_req = vecs[i].d_req;
      d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; mem_ready = vecs[i].ready;
      step();
      check($sformatf("fetch_vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
    end

    // Reset asserted mid-ACCESS clears outputs at once and no ack follows.
    do_reset();
    f_req = 1'b1; f_addr = 6'h2A; mem_ready = 1'b0;
    step(); step(); step();
    check("in_access", 32'(mem_en), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(dut_out()), 32'(0));
    f_req = 1'b0;
    step();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (f_ack || d_ack) acks++;
    end
    check("no_ack_after_reset", 32'(acks), 32'(0));
    check("idle_after_reset", 32'(busy), 32'(0));

    // Continuous contention alternates F, D, F, D.
    do_reset();
    f_req = 1'b1; f_addr = 6'h2A; d_req = 1'b1; d_we = 1'b1; d_addr = 6'h05; mem_ready = 1'b1;
    we_seen = 1'b0;
    for (int i = 0; i < 60 && order.size() < 4; i++) begin
      step();
      if (mem_en && mem_we) we_seen = 1'b1;
      if (f_ack || d_ack) begin
        order.push_back(d_ack ? 1 : 0);
        check("tie_mar", 32'(mar_in), d_ack ? 32'h05 : 32'h2A);
        check("tie_we", 32'(we_seen), 32'(d_ack));
        we_seen = 1'b0;
      end
    end
    check("tie_count", 32'(order.size()), 32'(4));
    for (int i = 0; i < order.size() && i < 4; i++)
      check($sformatf("tie_order%0d", i), 32'(order[i]), 32'(i % 2));
    f_req = 1'b0; d_req = 1'b0;

    // Data access with memory never ready times out after TIMEOUT access cycles.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'h3F; mem_ready = 1'b0;
    en_cnt = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (mem_en) en_cnt++;
      if (d_ack) begin
        got = 1'b1;
        check("tmo_err", 32'({d_err, f_ack, f_err}), 32'(3'b100));
      end
    end
    check("tmo_ack_seen", 32'(got), 32'(1));
    check("tmo_en_cycles", 32'(en_cnt), 32'(TMO));
    d_req = 1'b0;
    step();
    check("tmo_ack_pulse", 32'({d_ack, d_err}), 32'(0));

    // WAIT_CYCLES=3 instance: access lasts exactly 4 cycles with memory ready.
    do_reset();
    f_req = 1'b1; f_addr = 6'h15; mem_ready = 1'b1;
    en_cnt = 0; lss = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (mem_en3) en_cnt++;
      if (mar_ls3) lss++;
      if (f_ack3) begin
        got = 1'b1;
        check("w3_resp", 32'({mar_in3, mem_we3, d_ack3, d_err3, f_err3, busy3}),
              32'({6'h15, 5'b00001}));
      end
    end
    check("w3_ack_seen", 32'(got), 32'(1));
    check("w3_access_cycles", 32'(en_cnt), 32'(4));
    check("w3_loads", 32'(lss), 32'(1));
    f_req = 1'b0;

    // Data request dropped during ACCESS still completes with exactly one ack.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'h11; mem_ready = 1'b0;
    step(); step();
    d_req = 1'b0; mem_ready = 1'b1;
    acks = 0; lss = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (d_ack) acks++;
      if (mar_ls) lss++;
    end
    check("drop_ack_once", 32'(acks), 32'(1));
    check("drop_no_regrant", 32'(lss), 32'(0));
    check("drop_idle", 32'(busy), 32'(0));

    // Randomized traffic against the reference model.
    do_reset();
    bias = 3;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) bias = int'($urandom_range(0, 4));
      mem_ready = (bias == 0) ? 1'b0 : ($urandom % bias == 0);
      if (f_ack) f_req = ($urandom % 4 == 0);
      else if (!f_req && ($urandom % 3 == 0)) begin f_req = 1'b1; f_addr = AW'($urandom); end
      else if (f_req && ($urandom % 40 == 0)) f_req = 1'b0;
      if (d_ack) d_req = ($urandom % 4 == 0);
      else if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1'b1; d_addr = AW'($urandom); d_we = 1'($urandom);
      end
      else if (d_req && ($urandom % 40 == 0)) d_req = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
